// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU arbiter: one request payload per requester.
package alu_arb_pkg;
  localparam int XLEN         = 32;
  localparam int ALUCTRL_W    = 4;
  localparam int BRANCHCTRL_W = 3;

  typedef struct packed {
    logic [XLEN-1:0]         srca;
    logic [XLEN-1:0]         srcb;
    logic [ALUCTRL_W-1:0]    aluctrl;
    logic [BRANCHCTRL_W-1:0] branchctrl;
  } alu_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);
  int idx;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    if (en) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        idx = (int'(ptr) + i) % NUM_REQ;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          gnt_id   = ID_W'(idx);
        end
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters; result lands in a
// one-entry response register tagged with the winning requester ID.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int DATAWIDTH = XLEN,
  parameter  int NUM_REQ   = 2,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]     req_srca_i,
  input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]     req_srcb_i,
  input  logic [NUM_REQ-1:0][ALUCTRL_W-1:0]     req_aluctrl_i,
  input  logic [NUM_REQ-1:0][BRANCHCTRL_W-1:0]  req_branchctrl_i,
  output logic [DATAWIDTH-1:0]                  SrcA_o,
  output logic [DATAWIDTH-1:0]                  SrcB_o,
  output logic [ALUCTRL_W-1:0]                  ALUctrl_o,
  output logic [BRANCHCTRL_W-1:0]               BranchCtrl_o,
  input  logic [DATAWIDTH-1:0]                  ALUResult_i,
  input  logic                                  Branch_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [ID_W-1:0]                       rsp_id_o,
  output logic [DATAWIDTH-1:0]                  rsp_result_o,
  output logic                                  rsp_branch_o,
  output logic [15:0]                           stall_cnt_o
);
  logic               acc_en, xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id, rr_ptr;
  alu_req_t           drv;

  // The response slot can take a new entry when empty or being drained.
  assign acc_en = !rsp_valid_o || rsp_ready_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req_valid_i),
    .ptr    (rr_ptr),
    .en     (acc_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready_o = gnt;
  assign xfer        = |gnt;

  always_comb begin
    drv = '0;
    if (xfer) begin
      drv.srca       = XLEN'(req_srca_i[gnt_id]);
      drv.srcb       = XLEN'(req_srcb_i[gnt_id]);
      drv.aluctrl    = req_aluctrl_i[gnt_id];
      drv.branchctrl = req_branchctrl_i[gnt_id];
    end
  end

  assign SrcA_o       = DATAWIDTH'(drv.srca);
  assign SrcB_o       = DATAWIDTH'(drv.srcb);
  assign ALUctrl_o    = drv.aluctrl;
  assign BranchCtrl_o = drv.branchctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      rsp_branch_o <= 1'b0;
      rr_ptr       <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (xfer) begin
        rsp_valid_o  <= 1'b1;
        rsp_id_o     <= gnt_id;
        rsp_result_o <= ALUResult_i;
        rsp_branch_o <= Branch_i;
        rr_ptr       <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end else if (rsp_ready_i) begin
        rsp_valid_o  <= 1'b0;
      end
      if (|req_valid_i && !acc_en && stall_cnt_o != 16'hFFFF)
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an adder ALU (result A+B, branch A==B).
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int NR = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [NR-1:0]           req_valid, req_ready;
  logic [NR-1:0][DW-1:0]   srca, srcb;
  logic [NR-1:0][3:0]      aluctrl;
  logic [NR-1:0][2:0]      brctrl;
  logic [DW-1:0]           SrcA, SrcB, alu_res;
  logic [3:0]              aluc;
  logic [2:0]              brc;
  logic                    branch;
  logic                    rsp_valid, rsp_ready, rsp_branch;
  logic [0:0]              rsp_id;
  logic [DW-1:0]           rsp_result;
  logic [15:0]             stall_cnt;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        br;
  } exp_t;

  exp_t        sbq[$];
  int          m_ptr, m_id;
  logic        m_valid, m_br;
  logic [31:0] m_res;
  logic [15:0] m_stall;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign alu_res = SrcA + SrcB;
  assign branch  = (SrcA == SrcB);

  alu_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_srca_i       (srca),
    .req_srcb_i       (srcb),
    .req_aluctrl_i    (aluctrl),
    .req_branchctrl_i (brctrl),
    .SrcA_o           (SrcA),
    .SrcB_o           (SrcB),
    .ALUctrl_o        (aluc),
    .BranchCtrl_o     (brc),
    .ALUResult_i      (alu_res),
    .Branch_i         (branch),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_id_o         (rsp_id),
    .rsp_result_o     (rsp_result),
    .rsp_branch_o     (rsp_branch),
    .stall_cnt_o      (stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (p + i) % NR;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_res = '0; m_br = 1'b0; m_stall = '0;
    sbq.delete();
  endtask

  // Assert reset between edges and check the asynchronous clear.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid",  rsp_valid,  0);
    chk("rst_id",     rsp_id,     0);
    chk("rst_result", rsp_result, 0);
    chk("rst_branch", rsp_branch, 0);
    chk("rst_stall",  stall_cnt,  0);
  endtask

  // Called just after a rising edge with inputs already set.
  task automatic cycle();
    int   g;
    logic acc;
    exp_t e;
    @(negedge clk);
    acc = !m_valid || rsp_ready;
    g   = acc ? exp_grant(req_valid, m_ptr) : -1;
    chk("req_ready",   req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("srca_drv",    SrcA, (g >= 0) ? srca[g] : 0);
    chk("srcb_drv",    SrcB, (g >= 0) ? srcb[g] : 0);
    chk("aluctrl_drv", aluc, (g >= 0) ? aluctrl[g] : 0);
    chk("brctrl_drv",  brc,  (g >= 0) ? brctrl[g] : 0);
    if (|req_valid && !acc && m_stall != 16'hFFFF) m_stall++;
    if (g >= 0) begin
      sbq.push_back('{g, srca[g] + srcb[g], srca[g] == srcb[g]});
      m_ptr   = (g + 1) % NR;
      m_valid = 1'b1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (g >= 0 && sbq.size() > 0) begin
      e = sbq.pop_front();
      m_id = e.id; m_res = e.res; m_br = e.br;
    end
    chk("rsp_valid",  rsp_valid,  m_valid);
    chk("rsp_id",     rsp_id,     m_id);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_branch", rsp_branch, m_br);
    chk("stall_cnt",  stall_cnt,  m_stall);
  endtask

  initial begin
    req_valid = '0; rsp_ready = 1'b1;
    srca = '0; srcb = '0;
    aluctrl = {4'h3, 4'h5};
    brctrl  = {3'd6, 3'd1};
    #1;
    do_reset();
    chk("rst_ready", req_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request from requester 0
    srca[0] = 32'd5; srcb[0] = 32'd7; req_valid = 2'b01;
    cycle();
    chk("single_res", rsp_result, 12);
    chk("single_id",  rsp_id,     0);
    chk("single_br",  rsp_branch, 0);
    req_valid = '0;
    cycle();

    // One requester-1 transfer returns the pointer to 0
    srca[1] = 32'd3; srcb[1] = 32'd4; req_valid = 2'b10;
    cycle();
    req_valid = '0;

    // Round-robin with both valid
    srca[0] = 32'd10; srcb[0] = 32'd1; srca[1] = 32'd20; srcb[1] = 32'd2;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_id", rsp_id, i % 2);
    end

    // Backpressure: response held, requester 1 waits
    rsp_ready = 1'b0;
    srca[1] = 32'd9; srcb[1] = 32'd9; req_valid = 2'b10;
    repeat (3) cycle();
    chk("bp_stall", stall_cnt, 3);
    chk("bp_hold",  rsp_result, 22);
    rsp_ready = 1'b1;
    cycle();
    chk("bp_res", rsp_result, 18);
    chk("bp_br",  rsp_branch, 1);

    // Drain and accept in the same cycle
    srca[0] = 32'd20; srcb[0] = 32'd1; req_valid = 2'b01;
    cycle();
    chk("da_valid", rsp_valid, 1);
    chk("da_res",   rsp_result, 21);
    chk("da_id",    rsp_id, 0);
    req_valid = '0;

    // Reset mid-flight with a pending response and two stall cycles
    do_reset();
    #1 rst_n = 1'b1;
    srca[0] = 32'd2; srcb[0] = 32'd4; req_valid = 2'b01; rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    repeat (2) cycle();
    chk("mid_stall", stall_cnt, 2);
    chk("mid_valid", rsp_valid, 1);
    req_valid = 2'b11;
    #1;
    do_reset();
    chk("mid_rst_ready", req_ready, 2'b01);
    #1 rst_n = 1'b1;
    cycle();
    chk("post_rst_id", rsp_id, 0);

    // Stall counter saturation
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_stall", stall_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
